multicycle_ctrl: RTL and testbench

Main control unit for the multi-cycle processor. A registered Moore/Mealy FSM sequences each instruction through fetch, decode, execute, memory and write-back. It drives the datapath mux selects (PC source, ALU operand A/B, IorD, RegDst, MemtoReg) and the register/memory enables. It handshakes with a variable-latency memory through `mem_ready`, and keeps a retired-instruction counter.

---
 rtl/multicycle_ctrl.sv | 205 ++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl
//
// Main control unit for a multi-cycle processor. A registered FSM walks each
// instruction through fetch, decode, execute, memory and write-back. It
// drives the datapath mux selects and the register and memory enables. It
// waits on a variable-latency memory through mem_ready, and counts retired
// instructions.
//
// Ports
//   clk, rst_n        rising-edge clock, asynchronous active-low reset
//   opcode            IR opcode, stable from DECODE onward
//   zero              ALU zero flag, used in BRANCH
//   mem_ready         memory finishes the current access this cycle
//   mem_read/write    memory strobes
//   iord              address select: 0 = PC, 1 = ALUOut
//   ir_write, pc_write, reg_write   register enables
//   alu_src_a         0 = PC, 1 = reg A
//   alu_src_b         00 = B, 01 = 4, 10 = sext imm, 11 = imm<<2
//   alu_op            00 = add, 01 = sub, 10 = funct
//   pc_src            00 = ALU result, 01 = ALUOut, 10 = jump target
//   reg_dst           0 = rt, 1 = rd
//   mem_to_reg        0 = ALUOut, 1 = MDR
//   illegal_op        one-cycle pulse on an unknown opcode
//   instr_done        one-cycle pulse on the last cycle of an instruction
//   retired           count of completed instructions (wraps)
//   state             current state code, for debug
module multicycle_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_read,
  output logic             mem_write,
  output logic             iord,
  output logic             ir_write,
  output logic             pc_write,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [1:0]       pc_src,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             illegal_op,
  output logic             instr_done,
  output logic [CNT_W-1:0] retired,
  output logic [3:0]       state
);

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_ADDI = 6'h08;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXEC    = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JUMP    = 4'd11,
    S_ILLEGAL = 4'd12
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] retired_q, retired_d;

  // Reset is asynchronous, so the FETCH decode appears at the outputs
  // as soon as rst_n falls. An in-flight MEMWR is dropped without being
  // counted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      retired_q <= retired_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    iord       = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    pc_src     = 2'b00;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    illegal_op = 1'b0;
    instr_done = 1'b0;

    case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        // IR and PC load only on the cycle the memory delivers the word.
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        if (mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        // Precompute the branch target into ALUOut while decoding.
        alu_src_b = 2'b11;
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
          default:      state_d = S_ILLEGAL;
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWR: begin
        mem_write  = 1'b1;
        iord       = 1'b1;
        // A store retires on the cycle its write completes.
        instr_done = mem_ready;
        if (mem_ready) state_d = S_FETCH;
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
        state_d   = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write  = 1'b1;
        reg_dst    = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a  = 1'b1;
        alu_op     = 2'b01;
        pc_src     = 2'b01;
        pc_write   = zero;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = S_ADDIWB;
      end
      S_ADDIWB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_JUMP: begin
        pc_src     = 2'b10;
        pc_write   = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_ILLEGAL: begin
        // PC already advanced by 4 in FETCH, so just resume fetching.
        illegal_op = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      default: begin
        // Unused codes 13-15 recover to FETCH with every output at 0.
        state_d = S_FETCH;
      end
    endcase
  end

  assign retired_d = instr_done ? retired_q + CNT_W'(1) : retired_q;
  assign retired   = retired_q;
  assign state     = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [5:0]  opcode = 6'h00;
  logic        zero = 1'b0;
  logic        mem_ready = 1'b0;

  logic        mem_read, mem_write, iord, ir_write, pc_write, reg_write;
  logic        alu_src_a, reg_dst, mem_to_reg, illegal_op, instr_done;
  logic [1:0]  alu_src_b, alu_op, pc_src;
  logic [15:0] retired;
  logic [3:0]  state;

  // Narrow-counter instance sharing the same stimulus, used to see the wrap.
  logic        s_mem_read, s_mem_write, s_iord, s_ir_write, s_pc_write, s_reg_write;
  logic        s_alu_src_a, s_reg_dst, s_mem_to_reg, s_illegal_op, s_instr_done;
  logic [1:0]  s_alu_src_b, s_alu_op, s_pc_src;
  logic [2:0]  s_retired;
  logic [3:0]  s_state;

  always #5 clk = ~clk;

  multicycle_ctrl #(.CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .mem_read(mem_read), .mem_write(mem_write), .iord(iord), .ir_write(ir_write),
    .pc_write(pc_write), .reg_write(reg_write), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_src(pc_src), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .illegal_op(illegal_op), .instr_done(instr_done),
    .retired(retired), .state(state)
  );

  multicycle_ctrl #(.CNT_W(3)) dut_s (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .mem_read(s_mem_read), .mem_write(s_mem_write), .iord(s_iord), .ir_write(s_ir_write),
    .pc_write(s_pc_write), .reg_write(s_reg_write), .alu_src_a(s_alu_src_a),
    .alu_src_b(s_alu_src_b), .alu_op(s_alu_op), .pc_src(s_pc_src), .reg_dst(s_reg_dst),
    .mem_to_reg(s_mem_to_reg), .illegal_op(s_illegal_op), .instr_done(s_instr_done),
    .retired(s_retired), .state(s_state)
  );

  // Observed control word:
  // {mem_read, mem_write, iord, ir_write, pc_write, reg_write, alu_src_a,
  //  alu_src_b[1:0], alu_op[1:0], pc_src[1:0], reg_dst, mem_to_reg,
  //  illegal_op, instr_done}
  logic [16:0] ctlw;
  assign ctlw = {mem_read, mem_write, iord, ir_write, pc_write, reg_write, alu_src_a,
                 alu_src_b, alu_op, pc_src, reg_dst, mem_to_reg, illegal_op, instr_done};

  // Hand-written expected control words, one per state/condition.
  localparam int K_FW = 0, K_FG = 1, K_DEC = 2, K_MADR = 3, K_MRD = 4, K_MWB = 5;
  localparam int K_MWRW = 6, K_MWRG = 7, K_EXEC = 8, K_ALUWB = 9, K_BRT = 10;
  localparam int K_BRN = 11, K_AEX = 12, K_AWB = 13, K_JMP = 14, K_ILL = 15;

  function automatic logic [16:0] kw(input int k);
    case (k)
      //                      mr   mw   io   irw  pcw  rw   asa  asb    aop    psrc   rd   m2r  ill  done
      K_FW:    kw = {1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,2'b00,2'b00,1'b0,1'b0,1'b0,1'b0};
      K_FG:    kw = {1'b1,1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,2'b01,2'b00,2'b00,1'b0,1'b0,1'b0,1'b0};
      K_DEC:   kw = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b11,2'b00,2'b00,1'b0,1'b0,1'b0,1'b0};
      K_MADR:  kw = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,2'b00,2'b00,1'b0,1'b0,1'b0,1'b0};
      K_MRD:   kw = {1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,1'b0,1'b0,1'b0,1'b0};
      K_MWB:   kw = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,2'b00,2'b00,2'b00,1'b0,1'b1,1'b0,1'b1};
      K_MWRW:  kw = {1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,1'b0,1'b0,1'b0,1'b0};
      K_MWRG:  kw = {1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,1'b0,1'b0,1'b0,1'b1};
      K_EXEC:  kw = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b10,2'b00,1'b0,1'b0,1'b0,1'b0};
      K_ALUWB: kw = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,2'b00,2'b00,2'b00,1'b1,1'b0,1'b0,1'b1};
      K_BRT:   kw = {1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,2'b00,2'b01,2'b01,1'b0,1'b0,1'b0,1'b1};
      K_BRN:   kw = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b01,2'b01,1'b0,1'b0,1'b0,1'b1};
      K_AEX:   kw = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,2'b00,2'b00,1'b0,1'b0,1'b0,1'b0};
      K_AWB:   kw = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,2'b00,2'b00,2'b00,1'b0,1'b0,1'b0,1'b1};
      K_JMP:   kw = {1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,2'b00,2'b00,2'b10,1'b0,1'b0,1'b0,1'b1};
      default: kw = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,1'b0,1'b0,1'b1,1'b1};
    endcase
  endfunction

  typedef struct packed {
    logic [5:0]         op;
    logic               zero;
    logic [3:0]         len;
    logic [11:0]        rdy;
    logic [11:0][3:0]   st;
    logic [11:0][16:0]  ctl;
    logic [15:0]        ret;   // retired count visible during the done cycle
  } vec_t;

  vec_t sbq[$];
  vec_t cur;
  int   n_vec = 0;
  int   n_bad = 0;
  logic [15:0] exp_ret = 16'd0;

  // ---------------- stimulus helpers ----------------
  task automatic begin_vec(input logic [5:0] op, input logic z);
    cur = '0;
    cur.op = op;
    cur.zero = z;
  endtask

  task automatic step(input logic [3:0] s, input int k, input logic r);
    cur.st[cur.len]  = s;
    cur.ctl[cur.len] = kw(k);
    cur.rdy[cur.len] = r;
    cur.len = cur.len + 4'd1;
  endtask

  // Called at posedge+1 with the DUT in FETCH; returns at posedge+1 after
  // the instruction's last cycle.
  task automatic run_vec();
    cur.ret = exp_ret;
    sbq.push_back(cur);
    opcode = cur.op;
    zero   = cur.zero;
    for (int i = 0; i < int'(cur.len); i++) begin
      mem_ready = cur.rdy[i];
      @(posedge clk);
      #1;
    end
    exp_ret = exp_ret + 16'd1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic [11:0][3:0]  obs_st  = '0;
  logic [11:0][16:0] obs_ctl = '0;
  int                ncyc = 0;

  always @(negedge clk) begin
    vec_t e;
    if (!rst_n) begin
      ncyc    = 0;
      obs_st  = '0;
      obs_ctl = '0;
    end else begin
      if (ncyc < 12) begin
        obs_st[ncyc]  = state;
        obs_ctl[ncyc] = ctlw;
      end
      ncyc++;
      if (instr_done) begin
        if (sbq.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL unexpected_done: got done in state %0d, expected no instruction", state);
        end else begin
          e = sbq.pop_front();
          n_vec++;
          if (ncyc != int'(e.len)) begin
            n_bad++;
            $display("FAIL cycles op=%0h: got %0d expected %0d", e.op, ncyc, e.len);
          end
          n_vec++;
          if (obs_st !== e.st) begin
            n_bad++;
            $display("FAIL states op=%0h: got %h expected %h", e.op, obs_st, e.st);
          end
          n_vec++;
          if (obs_ctl !== e.ctl) begin
            n_bad++;
            $display("FAIL controls op=%0h: got %h expected %h", e.op, obs_ctl, e.ctl);
          end
          n_vec++;
          if (retired !== e.ret) begin
            n_bad++;
            $display("FAIL retired op=%0h: got %0d expected %0d", e.op, retired, e.ret);
          end
          n_vec++;
          if (s_retired !== e.ret[2:0]) begin
            n_bad++;
            $display("FAIL retired_narrow op=%0h: got %0d expected %0d", e.op, s_retired, e.ret[2:0]);
          end
          $display("instr op=%0h cycles=%0d retired=%0d", e.op, ncyc, retired);
        end
        ncyc    = 0;
        obs_st  = '0;
        obs_ctl = '0;
      end else if (ncyc > 16) begin
        n_vec++;
        n_bad++;
        $display("FAIL timeout: got %0d cycles without instr_done, expected at most 12", ncyc);
        ncyc    = 0;
        obs_st  = '0;
        obs_ctl = '0;
      end
    end
  end

  // ---------------- directed sequence ----------------
  initial begin
    #1 rst_n = 1'b0;
    #2;
    // Reset state before any clock edge.
    check("reset_state", 32'(state), 32'd0);
    check("reset_ctl", 32'(ctlw), 32'(kw(K_FW)));
    check("reset_retired", 32'(retired), 32'd0);
    $display("reset state=%0d ctl=%h retired=%0d", state, ctlw, retired);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // R-type: 0,1,6,7
    begin_vec(6'h00, 1'b0);
    step(4'd0, K_FG, 1'b1); step(4'd1, K_DEC, 1'b1); step(4'd6, K_EXEC, 1'b1);
    step(4'd7, K_ALUWB, 1'b1);
    run_vec();

    // LW with two wait cycles in MEMRD: 0,1,2,3,3,3,4
    begin_vec(6'h23, 1'b0);
    step(4'd0, K_FG, 1'b1); step(4'd1, K_DEC, 1'b1); step(4'd2, K_MADR, 1'b1);
    step(4'd3, K_MRD, 1'b0); step(4'd3, K_MRD, 1'b0); step(4'd3, K_MRD, 1'b1);
    step(4'd4, K_MWB, 1'b1);
    run_vec();

    // BEQ taken then not taken
    begin_vec(6'h04, 1'b1);
    step(4'd0, K_FG, 1'b1); step(4'd1, K_DEC, 1'b1); step(4'd8, K_BRT, 1'b1);
    run_vec();
    begin_vec(6'h04, 1'b0);
    step(4'd0, K_FG, 1'b1); step(4'd1, K_DEC, 1'b1); step(4'd8, K_BRN, 1'b1);
    run_vec();

    // Illegal opcode
    begin_vec(6'h3F, 1'b0);
    step(4'd0, K_FG, 1'b1); step(4'd1, K_DEC, 1'b1); step(4'd12, K_ILL, 1'b1);
    run_vec();

    // SW with one wait in FETCH and one in MEMWR
    begin_vec(6'h2B, 1'b0);
    step(4'd0, K_FW, 1'b0); step(4'd0, K_FG, 1'b1); step(4'd1, K_DEC, 1'b1);
    step(4'd2, K_MADR, 1'b1); step(4'd5, K_MWRW, 1'b0); step(4'd5, K_MWRG, 1'b1);
    run_vec();

    // ADDI: 0,1,9,10
    begin_vec(6'h08, 1'b0);
    step(4'd0, K_FG, 1'b1); step(4'd1, K_DEC, 1'b1); step(4'd9, K_AEX, 1'b1);
    step(4'd10, K_AWB, 1'b1);
    run_vec();

    // J: 0,1,11 -- the eighth instruction, so the 3-bit counter wraps to 0
    begin_vec(6'h02, 1'b0);
    step(4'd0, K_FG, 1'b1); step(4'd1, K_DEC, 1'b1); step(4'd11, K_JMP, 1'b1);
    run_vec();
    check("retired_after_j", 32'(retired), 32'd8);
    check("retired_wrap", 32'(s_retired), 32'd0);
    $display("wrap retired=%0d narrow=%0d", retired, s_retired);

    // Reset in the middle of a stalled store.
    opcode = 6'h2B;
    mem_ready = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    mem_ready = 1'b0;
    #2;
    check("memwr_state", 32'(state), 32'd5);
    check("memwr_strobe", 32'(mem_write), 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort_mem_write", 32'(mem_write), 32'd0);
    check("abort_state", 32'(state), 32'd0);
    check("abort_retired", 32'(retired), 32'd0);
    check("abort_retired_narrow", 32'(s_retired), 32'd0);
    $display("abort state=%0d mem_write=%0d retired=%0d", state, mem_write, retired);
    exp_ret = 16'd0;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // R-type after reset, with a FETCH stall; counting restarts from 0.
    begin_vec(6'h00, 1'b0);
    step(4'd0, K_FW, 1'b0); step(4'd0, K_FW, 1'b0); step(4'd0, K_FG, 1'b1);
    step(4'd1, K_DEC, 1'b1); step(4'd6, K_EXEC, 1'b1); step(4'd7, K_ALUWB, 1'b1);
    run_vec();
    check("retired_final", 32'(retired), 32'd1);

    mem_ready = 1'b0;
    repeat (4) @(posedge clk);
    check("scoreboard_drained", 32'(sbq.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
